// File: rtl/uartms_pkg.sv
// uartms_pkg: shared types and constants for the UART auto-sync transmitter
package uartms_pkg;
  typedef enum logic [2:0] {IDLE, GUARD, START, DATA, STOP, DONE} sync_state_t;
  localparam logic [7:0] SYNC_CHAR = 8'h55;
  localparam int BITS_PER_FRAME = 10;
endpackage

// File: rtl/uartms_baud_tick.sv
// uartms_baud_tick: 16x baud divider, pulses tick16 once per (div+1) cycles while clr is low
module uartms_baud_tick #(
  parameter int BAUDW = 12
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             clr,
  input  logic [BAUDW-1:0] div,
  output logic             tick16
);
  logic [BAUDW-1:0] cnt;
  assign tick16 = !clr && cnt == div;
  always_ff @(posedge mclk)
    if (reset || clr) cnt <= '0;
    else cnt <= tick16 ? '0 : cnt + BAUDW'(1);
endmodule

// File: rtl/uartms_auto_sync_tx.sv
// uartms_auto_sync_tx: sends an idle guard then NUM_CHAR 8N1 sync characters for far-end auto-baud lock
module uartms_auto_sync_tx
  import uartms_pkg::*;
#(
  parameter int BAUDW      = 12,
  parameter int NUM_CHAR   = 2,
  parameter int GUARD_BITS = 12
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             cfg_enable,
  input  logic [BAUDW-1:0] cfg_baud_16x,
  input  logic             sync_req,
  output logic             sync_busy,
  output logic             sync_done,
  output logic             txd
);
  sync_state_t      state;
  logic [BAUDW-1:0] n_lat;
  logic [3:0]       tick_cnt, char_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       guard_cnt;
  logic             tick16, clr, bit_end;
  assign clr     = state == IDLE || state == DONE || !cfg_enable;
  assign bit_end = tick16 && tick_cnt == 4'd15;
  uartms_baud_tick #(.BAUDW(BAUDW)) u_tick (
    .mclk  (mclk),
    .reset (reset),
    .clr   (clr),
    .div   (n_lat),
    .tick16(tick16)
  );
  always_ff @(posedge mclk) begin
    if (reset || (state != IDLE && !cfg_enable)) begin
      state     <= IDLE;
      txd       <= 1'b1;
      sync_busy <= 1'b0;
      sync_done <= 1'b0;
      tick_cnt  <= '0;
      char_cnt  <= '0;
      bit_idx   <= '0;
      guard_cnt <= '0;
      if (reset) n_lat <= '0;
    end else begin
      sync_done <= 1'b0;
      if (tick16) tick_cnt <= bit_end ? 4'd0 : tick_cnt + 4'd1;
      case (state)
        IDLE:
          if (cfg_enable && sync_req) begin
            state     <= GUARD;
            n_lat     <= cfg_baud_16x;
            sync_busy <= 1'b1;
            tick_cnt  <= '0;
            char_cnt  <= '0;
            bit_idx   <= '0;
            guard_cnt <= '0;
          end
        GUARD:
          if (bit_end) begin
            if (guard_cnt == 8'(GUARD_BITS - 1)) begin
              state     <= START;
              txd       <= 1'b0;
              guard_cnt <= '0;
            end else guard_cnt <= guard_cnt + 8'd1;
          end
        START:
          if (bit_end) begin
            state   <= DATA;
            txd     <= SYNC_CHAR[0];
            bit_idx <= '0;
          end
        DATA:
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              txd     <= 1'b1;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= SYNC_CHAR[bit_idx + 3'd1];
            end
          end
        STOP:
          if (bit_end) begin
            // char_cnt counts finished frames, so it survives START/DATA/STOP re-entry
            if (char_cnt == 4'(NUM_CHAR - 1)) begin
              state     <= DONE;
              sync_busy <= 1'b0;
              sync_done <= 1'b1;
              char_cnt  <= '0;
            end else begin
              state    <= START;
              txd      <= 1'b0;
              char_cnt <= char_cnt + 4'd1;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
